// File: rtl/alu_int_if.sv
// Operand/result bundle between the issue logic and the integer ALU.
// master drives OP1/OP2/ALU_OP; slave (the ALU) returns RESULT and flags.
interface alu_int_if;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [4:0]  ALU_OP;
    logic [31:0] RESULT;
    logic        ZERO;
    logic        SIGN_BIT;
    logic        SLTU_BIT;

    modport master (
        output OP1, OP2, ALU_OP,
        input  RESULT, ZERO, SIGN_BIT, SLTU_BIT
    );

    modport slave (
        input  OP1, OP2, ALU_OP,
        output RESULT, ZERO, SIGN_BIT, SLTU_BIT
    );
endinterface

// File: rtl/alu_int.sv
// Execute-stage integer ALU: RV32I ops, optional RV32M via ALU_INT_MEXT_EN.
// Ports: CLK, RESET (async, active-high), bus (alu_int_if.slave): OP1,
// OP2, ALU_OP in; registered RESULT, ZERO, SIGN_BIT, SLTU_BIT out.
module alu_int (
    input logic       CLK,
    input logic       RESET,
    alu_int_if.slave  bus
);
    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b01000;
    localparam logic [4:0] OP_SLL    = 5'b00001;
    localparam logic [4:0] OP_SLT    = 5'b00010;
    localparam logic [4:0] OP_SLTU   = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SRL    = 5'b00101;
    localparam logic [4:0] OP_SRA    = 5'b01101;
    localparam logic [4:0] OP_OR     = 5'b00110;
    localparam logic [4:0] OP_AND    = 5'b00111;
    localparam logic [4:0] OP_FWD    = 5'b11000;
`ifdef ALU_INT_MEXT_EN
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;
`endif

    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] res_next;

    assign op1   = bus.OP1;
    assign op2   = bus.OP2;
    assign shamt = op2[4:0];

`ifdef ALU_INT_MEXT_EN
    // One shared 33x33 signed multiplier; the extra top bit carries
    // either the sign or a zero, which selects signed/unsigned operands.
    logic               mul_a_sgn;
    logic               mul_b_sgn;
    logic [32:0]        mul_a;
    logic [32:0]        mul_b;
    logic signed [63:0] prod;

    assign mul_a_sgn = (bus.ALU_OP == OP_MULH)
                     | (bus.ALU_OP == OP_MULHSU);
    assign mul_b_sgn = (bus.ALU_OP == OP_MULH);
    assign mul_a = {mul_a_sgn & op1[31], op1};
    assign mul_b = {mul_b_sgn & op2[31], op2};
    assign prod  = $signed({{31{mul_a[32]}}, mul_a})
                 * $signed({{31{mul_b[32]}}, mul_b});

    // One unsigned divider on magnitudes; signs are restored afterwards.
    // 0x80000000 / -1 falls out naturally: |q| = 2^31, negated back.
    logic        div_sgn;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_den;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q_out;
    logic [31:0] r_out;

    assign div_sgn  = (bus.ALU_OP == OP_DIV) | (bus.ALU_OP == OP_REM);
    assign a_neg    = div_sgn & op1[31];
    assign b_neg    = div_sgn & op2[31];
    assign abs_a    = a_neg ? (~op1 + 32'd1) : op1;
    assign abs_b    = b_neg ? (~op2 + 32'd1) : op2;
    assign div_zero = (op2 == 32'd0);
    assign div_den  = div_zero ? 32'd1 : abs_b;
    assign uq       = abs_a / div_den;
    assign ur       = abs_a % div_den;
    assign q_out    = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    assign r_out    = a_neg ? (~ur + 32'd1) : ur;
`endif

    always_comb begin
        res_next = '0;
        unique case (bus.ALU_OP)
            OP_ADD:  res_next = op1 + op2;
            OP_SUB:  res_next = op1 - op2;
            OP_SLL:  res_next = op1 << shamt;
            OP_SLT:  res_next = {31'b0, $signed(op1) < $signed(op2)};
            OP_SLTU: res_next = {31'b0, op1 < op2};
            OP_XOR:  res_next = op1 ^ op2;
            OP_SRL:  res_next = op1 >> shamt;
            OP_SRA:  res_next = $unsigned($signed(op1) >>> shamt);
            OP_OR:   res_next = op1 | op2;
            OP_AND:  res_next = op1 & op2;
            OP_FWD:  res_next = op2;
`ifdef ALU_INT_MEXT_EN
            OP_MUL:    res_next = prod[31:0];
            OP_MULH:   res_next = prod[63:32];
            OP_MULHSU: res_next = prod[63:32];
            OP_MULHU:  res_next = prod[63:32];
            OP_DIV:    res_next = div_zero ? 32'hFFFF_FFFF : q_out;
            OP_DIVU:   res_next = div_zero ? 32'hFFFF_FFFF : q_out;
            OP_REM:    res_next = div_zero ? op1 : r_out;
            OP_REMU:   res_next = div_zero ? op1 : r_out;
`endif
            default: res_next = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.RESULT   <= '0;
            bus.ZERO     <= 1'b0;
            bus.SIGN_BIT <= 1'b0;
            bus.SLTU_BIT <= 1'b0;
        end else begin
            bus.RESULT   <= res_next;
            bus.ZERO     <= (res_next == 32'd0);
            bus.SIGN_BIT <= res_next[31];
            bus.SLTU_BIT <= (op1 < op2);
        end
    end
endmodule

// File: tb/tb_alu_int.sv
// Scoreboard testbench for alu_int: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_int;
    logic clk;
    logic rst;

    alu_int_if bus ();

    alu_int u_dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        s;
        logic        c;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] ref_result(
        input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa  = longint'($signed(a));
        longint          sbv = longint'($signed(b));
        longint unsigned ua  = 64'(a);
        longint unsigned ub  = 64'(b);
        longint unsigned pw  = 64'd1 << b[4:0];
        longint          spw = longint'(pw);
        logic [63:0]     p;
        case (op)
            5'b00000: return 32'(ua + ub);
            5'b01000: return 32'(ua - ub);
            5'b00001: return 32'(ua * pw);
            5'b00010: return (sa < sbv) ? 32'd1 : 32'd0;
            5'b00011: return (ua < ub) ? 32'd1 : 32'd0;
            5'b00100: return a ^ b;
            5'b00101: return 32'(ua / pw);
            5'b01101: begin
                if (sa >= 0) return 32'(sa / spw);
                return 32'(-((-sa + spw - 1) / spw));
            end
            5'b00110: return a | b;
            5'b00111: return a & b;
            5'b11000: return b;
`ifdef ALU_INT_MEXT_EN
            5'b10000: return 32'(ua * ub);
            5'b10001: begin p = 64'(sa * sbv); return p[63:32]; end
            5'b10010: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            5'b10011: begin p = ua * ub; return p[63:32]; end
            5'b10100: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sbv);
            5'b10101: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            5'b10110: return (b == 0) ? a : 32'(sa % sbv);
            5'b10111: return (b == 0) ? a : 32'(ua % ub);
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        bus.ALU_OP = op;
        bus.OP1    = a;
        bus.OP2    = b;
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.res = ref_result(op, a, b);
        e.z   = (e.res == 32'd0);
        e.s   = e.res[31];
        e.c   = (a < b);
        sb.push_back(e);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (bus.RESULT !== 32'd0 || bus.ZERO !== 1'b0 ||
            bus.SIGN_BIT !== 1'b0 || bus.SLTU_BIT !== 1'b0) begin
            errors++;
            $display("FAIL %s: got res=%h z=%b s=%b c=%b, want all zero",
                     name, bus.RESULT, bus.ZERO, bus.SIGN_BIT,
                     bus.SLTU_BIT);
        end
    endtask

    // Monitor: outputs settle at each rising edge; compare 1 ns later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.RESULT !== e.res || bus.ZERO !== e.z ||
                    bus.SIGN_BIT !== e.s || bus.SLTU_BIT !== e.c) begin
                    errors++;
                    $display({"FAIL op%b a=%h b=%h: got res=%h z=%b s=%b",
                              " c=%b, want res=%h z=%b s=%b c=%b"},
                             e.op, e.a, e.b, bus.RESULT, bus.ZERO,
                             bus.SIGN_BIT, bus.SLTU_BIT, e.res, e.z,
                             e.s, e.c);
                end
            end
        end
    end

    function automatic logic [31:0] rnd_operand();
        logic [31:0] sp [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF,
                                32'h8000_0000, 32'h7FFF_FFFF, 32'd33};
        case ($urandom_range(3))
            0:       return 32'($urandom_range(15));
            1:       return sp[$urandom_range(5)];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] ops [19] = '{5'h00, 5'h08, 5'h01, 5'h02, 5'h03,
                                 5'h04, 5'h05, 5'h0D, 5'h06, 5'h07,
                                 5'h18, 5'h10, 5'h11, 5'h12, 5'h13,
                                 5'h14, 5'h15, 5'h16, 5'h17};
        logic [4:0] op;
        int         budget;

        rst        = 1'b1;
        bus.OP1    = '0;
        bus.OP2    = '0;
        bus.ALU_OP = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Mid-cycle reset pulse with a nonzero result on the outputs.
        issue(5'b00000, 32'd1, 32'd2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        bus.ALU_OP = 5'b00000;
        bus.OP1    = 32'd7;
        bus.OP2    = 32'd9;
        @(posedge clk);
        #1;
        check_idle("held_in_reset");
        #2;
        rst = 1'b0;
        #1;
        check_idle("release_no_edge");
        issue(5'b00000, 32'd10, 32'd20);

        issue(5'b00001, 32'd5, 32'd2);
        issue(5'b00010, 32'hFFFF_FFFB, 32'd10);
        issue(5'b00011, 32'd5, 32'd10);
        issue(5'b00101, 32'h8000_0000, 32'd1);
        issue(5'b01101, 32'h8000_0000, 32'd1);
        issue(5'b01101, 32'h8000_0000, 32'd33);
        issue(5'b00100, 32'd1, 32'd2);
        issue(5'b00110, 32'd1, 32'd2);
        issue(5'b00111, 32'd3, 32'd2);
        issue(5'b01000, 32'd7, 32'd7);
        issue(5'b11000, 32'd0, 32'hFFFF_FFD6);
        issue(5'b10000, 32'd10, 32'd20);
        issue(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(5'b10100, 32'd100, 32'd20);
        issue(5'b10110, 32'd100, 32'd20);
        issue(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'b10101, 32'd5, 32'd0);
        issue(5'b10111, 32'd5, 32'd0);
        issue(5'b10100, 32'hFFFF_FFF9, 32'd0);
        issue(5'b11111, 32'd3, 32'd4);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) != 0) op = ops[$urandom_range(18)];
            else                        op = 5'($urandom);
            issue(op, rnd_operand(), rnd_operand());
        end

        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results still pending, want 0",
                     sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
